// File: rtl/myproject_mul_share_arb.sv
// Round-robin arbiter feeding one shared signed multiplier; 1-cycle latency, 1 result/cycle.
// Backpressure: no requester is granted while the result register is full and not draining.
module myproject_mul_share_arb #(
    parameter int N_REQ  = 4,
    parameter int DIN0_W = 14,
    parameter int DIN1_W = 9,
    parameter int DOUT_W = 22,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*DIN0_W-1:0]    req_din0,
    input  logic [N_REQ*DIN1_W-1:0]    req_din1,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [ID_W-1:0]            resp_id,
    output logic [DOUT_W-1:0]          resp_dout,
    output logic [15:0]                issue_cnt
);

    localparam int PROD_W = DIN0_W + DIN1_W;

    logic [ID_W-1:0]          last_grant;
    logic [ID_W-1:0]          win;
    logic                     found;
    logic                     slot_free;
    logic                     accept;
    logic signed [DIN0_W-1:0] op0;
    logic signed [DIN1_W-1:0] op1;
    logic signed [PROD_W-1:0] prod;

    // Search starts just past the last granted requester.
    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign slot_free = !resp_valid || resp_ready;

    // Gating with ap_rst_n keeps req_ready low throughout reset, independent of the clock.
    always_comb begin
        req_ready = '0;
        if (found && slot_free && ap_rst_n)
            req_ready[win] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    assign op0  = req_din0[int'(win)*DIN0_W +: DIN0_W];
    assign op1  = req_din1[int'(win)*DIN1_W +: DIN1_W];
    assign prod = PROD_W'(op0) * PROD_W'(op1);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_dout  <= '0;
            issue_cnt  <= '0;
            last_grant <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_id    <= win;
            resp_dout  <= prod[DOUT_W-1:0];
            issue_cnt  <= issue_cnt + 16'd1;
            last_grant <= win;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Scoreboard bench for the shared-multiplier arbiter.
module tb_myproject_mul_share_arb;

    localparam int N  = 4;
    localparam int A  = 14;
    localparam int B  = 9;
    localparam int D  = 22;
    localparam int IW = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*A-1:0]    req_din0 = '0;
    logic [N*B-1:0]    req_din1 = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [IW-1:0]     resp_id;
    logic [D-1:0]      resp_dout;
    logic [15:0]       issue_cnt;

    myproject_mul_share_arb #(.N_REQ(N), .DIN0_W(A), .DIN1_W(B), .DOUT_W(D)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_dout(resp_dout), .issue_cnt(issue_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [D-1:0]  dout;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    int          m_last = N - 1;
    bit          m_vld = 1'b0;
    logic [15:0] m_cnt = '0;

    function automatic logic [D-1:0] ref_prod(int g);
        logic signed [A-1:0] a;
        logic signed [B-1:0] b;
        longint p;
        a = req_din0[g*A +: A];
        b = req_din1[g*B +: B];
        p = longint'(a) * longint'(b);
        return p[D-1:0];
    endfunction

    function automatic int ref_winner();
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_vld  = 1'b0;
        m_cnt  = '0;
        sb.delete();
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_din0[i*A +: A] = A'(a);
        req_din1[i*B +: B] = B'(b);
    endtask

    // One clock of scoreboard checking: grant, held/draining result, then count.
    task automatic step();
        int   w;
        logic [N-1:0] er;
        exp_t f;
        #2;
        w  = ref_winner();
        er = '0;
        if ((!m_vld || resp_ready) && w >= 0) er[w] = 1'b1;
        total++;
        if (req_ready !== er) begin
            bad++;
            $display("FAIL req_ready: got %b want %b at %0t", req_ready, er, $time);
        end
        total++;
        if (resp_valid !== m_vld) begin
            bad++;
            $display("FAIL resp_valid: got %b want %b at %0t", resp_valid, m_vld, $time);
        end
        if (m_vld && sb.size() > 0) begin
            f = sb[0];
            total++;
            if (resp_id !== f.id || resp_dout !== f.dout) begin
                bad++;
                $display("FAIL resp_data: got id=%0d dout=%h want id=%0d dout=%h at %0t",
                         resp_id, resp_dout, f.id, f.dout, $time);
            end
            if (resp_ready) void'(sb.pop_front());
        end
        if (er != '0) begin
            f.id   = IW'(w);
            f.dout = ref_prod(w);
            sb.push_back(f);
            m_last = w;
            m_cnt  = m_cnt + 16'd1;
            m_vld  = 1'b1;
        end else if (resp_ready) begin
            m_vld = 1'b0;
        end
        @(posedge ap_clk);
        #1;
        total++;
        if (issue_cnt !== m_cnt) begin
            bad++;
            $display("FAIL issue_cnt: got %0d want %0d at %0t", issue_cnt, m_cnt, $time);
        end
    endtask

    task automatic apply_reset();
        req_valid = '0;
        ap_rst_n  = 1'b0;
        model_reset();
        @(posedge ap_clk);
        #3;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge ap_clk);
            #3;
            total++;
            if (resp_valid !== 1'b0 || resp_id !== '0 || resp_dout !== '0 ||
                issue_cnt !== 16'd0 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL reset_state: got vld=%b id=%0d dout=%h cnt=%0d rdy=%b want all zero",
                         resp_valid, resp_id, resp_dout, issue_cnt, req_ready);
            end
        end
        req_valid = '0;
        ap_rst_n  = 1'b1;
        model_reset();
        @(posedge ap_clk);
        #1;
        step();
    endtask

    task automatic test_single();
        logic [D-1:0] e;
        apply_reset();
        e = -22'sd300;
        set_ops(0, 100, -3);
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        step();
        req_valid = '0;
        #1;
        total++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_dout !== e || issue_cnt !== 16'd1) begin
            bad++;
            $display("FAIL single: got vld=%b id=%0d dout=%h cnt=%0d want 1 0 %h 1",
                     resp_valid, resp_id, resp_dout, issue_cnt, e);
        end
        step();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] oh;
        apply_reset();
        for (int i = 0; i < N; i++) set_ops(i, 1000 * (i + 1) - 4000, 7 * i - 11);
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            oh = 4'b0001 << (k % 4);
            #1;
            total++;
            if (req_ready !== oh) begin
                bad++;
                $display("FAIL rr_order: cycle %0d got %b want %b", k, req_ready, oh);
            end
            step();
        end
        req_valid = '0;
        total++;
        if (issue_cnt !== 16'd8) begin
            bad++;
            $display("FAIL rr_count: got %0d want 8", issue_cnt);
        end
        step();
    endtask

    task automatic test_backpressure();
        set_ops(0, -77, 45);
        set_ops(1, 321, -99);
        req_valid  = 4'b0001;
        resp_ready = 1'b0;
        step();
        req_valid = 4'b0010;
        repeat (5) step();
        resp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_release: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        total++;
        if (resp_id !== 2'd1 || resp_dout !== 22'(-31779)) begin
            bad++;
            $display("FAIL bp_result: got id=%0d dout=%h want id=1 dout=%h",
                     resp_id, resp_dout, 22'(-31779));
        end
        step();
    endtask

    task automatic test_overflow();
        set_ops(2, -8192, -256);
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        step();
        total++;
        if (resp_dout !== 22'h200000 || $signed(resp_dout) != -2097152) begin
            bad++;
            $display("FAIL ovf_neg: got %h want 200000", resp_dout);
        end
        set_ops(2, 8191, 255);
        step();
        req_valid = '0;
        total++;
        if (resp_dout !== 22'd2088705) begin
            bad++;
            $display("FAIL ovf_pos: got %0d want 2088705", resp_dout);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++)
                set_ops(i, $urandom_range(16383) - 8192, $urandom_range(511) - 256);
            req_valid  = N'($urandom_range(15));
            resp_ready = ($urandom_range(3) != 0);
            step();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        step();
    endtask

    task automatic test_mid_reset();
        set_ops(2, 55, 3);
        set_ops(3, -12, 12);
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        step();
        req_valid = 4'b1000;
        ap_rst_n  = 1'b0;
        #2;
        total++;
        if (resp_valid !== 1'b0 || issue_cnt !== 16'd0 || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset: got vld=%b cnt=%0d rdy=%b want 0 0 0000",
                     resp_valid, issue_cnt, req_ready);
        end
        #3;
        ap_rst_n = 1'b1;
        model_reset();
        req_valid = 4'b1001;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL post_reset_prio: got %b want 0001", req_ready);
        end
        req_valid  = 4'b1000;
        resp_ready = 1'b1;
        step();
        req_valid = '0;
        step();
    endtask

    task automatic test_wrap();
        apply_reset();
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        repeat (65535) @(posedge ap_clk);
        #1;
        total++;
        if (issue_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_max: got %h want ffff", issue_cnt);
        end
        @(posedge ap_clk);
        #1;
        req_valid = '0;
        total++;
        if (issue_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL wrap_zero: got %h want 0000", issue_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
